polylut_flow_ctrl: RTL and testbench

- Flow controller for the fixed-latency PolyLUT-Add inference pipeline. That pipeline is a chain of free-running layer and adder register stages with no enable and no stall.
- The block adds valid/ready handshaking around it and tracks in-flight samples with a valid shift register.
- Results are captured into an output FIFO. Input admission is credit-limited so no result is lost under output backpressure.
- Sits between the sample source and the pipeline input (M0), and between the pipeline output (M12) and the downstream consumer.

---
 rtl/polylut_flow_ctrl.sv | 108 ++++++++++
 tb/tb_polylut_flow_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/polylut_flow_ctrl.sv
// polylut_flow_ctrl: valid/ready wrapper with credit-limited admission around a fixed-latency, stall-free pipeline
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   sample handshake into the pipeline input
//   pipe_out            pipeline output, captured LATENCY edges after accept
//   out_valid/out_data  first-word-fall-through result FIFO head
//   out_ready           consumer pop
//   flush               discard all in-flight and buffered results (honoured in RUN only)
//   busy                any credit in use or not in RUN
//   in_count/out_count  wrapping accept/delivery counters
//   ovf_err             sticky: capture attempted into a full FIFO
module polylut_flow_ctrl #(
    parameter int LATENCY    = 12,
    parameter int OUT_W      = 20,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OUT_W-1:0] pipe_out,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] in_count,
    output logic [CNT_W-1:0] out_count,
    output logic             ovf_err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, CLR} state_t;

    state_t             state_q, state_d;
    logic [LATENCY-1:0] vsr_q, vsr_d;
    logic [AW:0]        used_q, used_d, wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic               ovf_q, ovf_d;
    logic [OUT_W-1:0]   mem_q [FIFO_DEPTH];
    logic               acc, pop, cap, empty, full, run, wr_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    // DRAIN waits for the last tracked sample to leave the pipeline before clearing
    always_comb begin
        state_d = state_q == RUN   ? (flush ? DRAIN : RUN) :
                  state_q == DRAIN ? (vsr_q == '0 ? CLR : DRAIN) : RUN;
    end

    // rst gating keeps in_ready low while reset is held
    always_comb begin
        run       = state_q == RUN;
        in_ready  = rst & run & (used_q < (AW+1)'(FIFO_DEPTH));
        out_valid = run & ~empty;
        busy      = (used_q != '0) | ~run;
    end

    always_comb begin
        empty     = wr_q == rd_q;
        full      = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
        acc       = in_valid & in_ready;
        pop       = out_valid & out_ready;
        cap       = vsr_q[LATENCY-1];
        // a pop in the same cycle frees the slot, so a full FIFO can still accept
        wr_en     = cap & run & (~full | pop);
        vsr_d     = {vsr_q[LATENCY-2:0], acc};
        used_d    = state_q == CLR ? '0 : used_q + (AW+1)'(acc) - (AW+1)'(pop);
        wr_d      = state_q == CLR ? '0 : wr_q + (AW+1)'(wr_en);
        rd_d      = state_q == CLR ? '0 : rd_q + (AW+1)'(pop);
        in_cnt_d  = in_cnt_q + CNT_W'(acc);
        out_cnt_d = out_cnt_q + CNT_W'(pop);
        ovf_d     = ovf_q | (cap & run & full & ~pop);
        out_data  = out_valid ? mem_q[rd_q[AW-1:0]] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsr_q     <= '0;
            used_q    <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            vsr_q     <= vsr_d;
            used_q    <= used_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= pipe_out;
    end

    assign in_count  = in_cnt_q;
    assign out_count = out_cnt_q;
    assign ovf_err   = ovf_q;
endmodule

// File: tb/tb_polylut_flow_ctrl.sv
// tb_polylut_flow_ctrl: directed scoreboard bench for polylut_flow_ctrl
module tb_polylut_flow_ctrl;
    localparam int LAT = 12;
    localparam int W   = 20;
    localparam int CW  = 4;

    logic          clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic          in_ready, out_valid, busy, ovf_err;
    logic [W-1:0]  pipe_out, out_data;
    logic [W-1:0]  in_data = '0;
    logic [CW-1:0] in_count, out_count;
    logic [W-1:0]  pipe [LAT];
    logic [W-1:0]  exp_q [$];
    int            n_tests = 0, n_fail = 0;

    polylut_flow_ctrl #(.LATENCY(LAT), .OUT_W(W), .FIFO_DEPTH(16), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pipe_out(pipe_out),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush),
        .busy(busy), .in_count(in_count), .out_count(out_count), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    // free-running stand-in for the inference pipeline: in_data appears on pipe_out LAT edges later
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= in_data;
    end
    assign pipe_out = pipe[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: handshakes are stable mid-cycle, so evaluate what the next edge will do
    always @(negedge clk) begin
        if (!rst) exp_q.delete();
        else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got 0x%0h expected no output", out_data);
                end else check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
            if (flush) exp_q.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, acc_n, first_low, popped, cyc, bad;
        #12;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_count", 32'(in_count), 0);
        check("rst_out_count", 32'(out_count), 0);
        check("rst_ovf", 32'(ovf_err), 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("release_in_ready", 32'(in_ready), 1);

        // single sample
        in_data = 20'h0ABCD; in_valid = 1'b1; tick();
        in_valid = 1'b0; in_data = 20'h12345;
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        check("single_latency", 32'(lat), 12);
        check("single_data", 32'(out_data), 32'h0ABCD);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("single_in_count", 32'(in_count), 1);
        check("single_out_count", 32'(out_count), 1);
        check("single_busy", 32'(busy), 0);
        check("single_out_valid", 32'(out_valid), 0);

        // backpressure: credits stop admission at 16
        acc_n = 0; first_low = -1;
        for (int i = 0; i < 30; i++) begin
            in_data = W'(32'h100 + i); in_valid = 1'b1;
            if (in_ready) acc_n++;
            else if (first_low < 0) first_low = i;
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(acc_n), 16);
        check("bp_first_low", 32'(first_low), 16);
        out_ready = 1'b1; popped = 0;
        for (int c = 0; c < 60 && popped < 16; c++) begin
            if (out_valid) popped++;
            tick();
        end
        out_ready = 1'b0;
        check("bp_popped", 32'(popped), 16);
        check("bp_in_ready", 32'(in_ready), 1);
        check("bp_busy", 32'(busy), 0);
        check("bp_ovf", 32'(ovf_err), 0);

        // full-boundary concurrency: after the first pop, one accept every cycle
        for (int i = 0; i < 16; i++) begin in_data = W'(32'h200 + i); in_valid = 1'b1; tick(); end
        in_valid = 1'b0;
        repeat (20) tick();
        check("full_in_ready", 32'(in_ready), 0);
        check("full_out_valid", 32'(out_valid), 1);
        out_ready = 1'b1; in_valid = 1'b1; acc_n = 0; cyc = 0;
        while (acc_n < 40 && cyc < 200) begin
            in_data = W'(32'h210 + acc_n);
            if (in_ready) acc_n++;
            tick(); cyc++;
        end
        in_valid = 1'b0;
        check("full_cycles", 32'(cyc), 41);
        cyc = 0;
        while (busy && cyc < 200) begin tick(); cyc++; end
        check("full_drained", 32'(busy), 0);
        check("full_in_count", 32'(in_count), 9);
        check("full_out_count", 32'(out_count), 9);
        out_ready = 1'b0;

        // flush with 3 buffered and 5 in flight
        for (int i = 0; i < 3; i++) begin in_data = W'(32'h300 + i); in_valid = 1'b1; tick(); end
        in_valid = 1'b0;
        repeat (14) tick();
        check("flush_buffered", 32'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin in_data = W'(32'h400 + i); in_valid = 1'b1; tick(); end
        in_valid = 1'b0;
        tick(); tick();
        flush = 1'b1; tick(); flush = 1'b0;
        out_ready = 1'b1; cyc = 0; bad = 0;
        while (!in_ready && cyc < 30) begin
            if (out_valid) bad++;
            tick(); cyc++;
        end
        check("flush_blocked_cycles", 32'(cyc), 11);
        check("flush_out_valid_seen", 32'(bad), 0);
        check("flush_busy", 32'(busy), 0);
        in_data = 20'h55555; in_valid = 1'b1; tick();
        in_valid = 1'b0; lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        check("flush_next_data", 32'(out_data), 32'h55555);
        tick();
        check("flush_in_count", 32'(in_count), 2);
        check("flush_out_count", 32'(out_count), 10);
        check("flush_ovf", 32'(ovf_err), 0);
        out_ready = 1'b0;

        // asynchronous reset with 7 in flight
        for (int i = 0; i < 7; i++) begin in_data = W'(32'h600 + i); in_valid = 1'b1; tick(); end
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("areset_in_ready", 32'(in_ready), 0);
        check("areset_out_valid", 32'(out_valid), 0);
        check("areset_busy", 32'(busy), 0);
        check("areset_in_count", 32'(in_count), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        out_ready = 1'b1; in_data = 20'h77777; in_valid = 1'b1; tick();
        in_valid = 1'b0; lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        check("areset_latency", 32'(lat), 12);
        check("areset_first_data", 32'(out_data), 32'h77777);
        tick();
        check("areset_out_count", 32'(out_count), 1);

        // counter wrap with 4-bit counters
        rst = 1'b0; tick(); tick();
        @(posedge clk);
        #3 rst = 1'b1;
        for (int i = 0; i < 18; i++) begin in_data = W'(32'h800 + i); in_valid = 1'b1; tick(); end
        in_valid = 1'b0; cyc = 0;
        while (busy && cyc < 100) begin tick(); cyc++; end
        check("wrap_idle", 32'(busy), 0);
        check("wrap_in_count", 32'(in_count), 2);
        check("wrap_out_count", 32'(out_count), 2);
        check("wrap_ovf", 32'(ovf_err), 0);
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
